dec_onehot_seq: RTL and testbench



---
 rtl/dec_onehot_seq.sv | 204 ++++++++++++++++++++
 tb/tb_dec_onehot_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq: sequential N-to-2^N one-hot decoder behind a valid/ready
// handshake. Each accepted index drives its one-hot select line for HOLD
// cycles, followed by GAP all-zero cycles. One further code can wait in a
// single pending slot while a pattern is in progress.
// Optional build macro DECODER_LOOPBACK_EN: re-encodes dout every cycle,
// compares it with the last loaded code and raises a sticky err on any
// mismatch or non-one-hot value. Without the macro, err is tied low.
module dec_onehot_seq #(
  parameter int N    = 3,
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [(1<<N)-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int W    = 1 << N;
  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [W-1:0]    dout_r, dout_s;
  logic            done_r, done_s;
  logic            pend_full_r, pend_full_s;
  logic [N-1:0]    pend_code_r, pend_code_s;
  logic            accept_s;

  // Decode an in-range binary index into its one-hot select pattern.
  function automatic logic [W-1:0] onehot(input logic [N-1:0] code);
    return {{(W-1){1'b0}}, 1'b1} << code;
  endfunction

  assign accept_s  = din_valid && !pend_full_r;
  assign din_ready = !pend_full_r;
  assign busy      = (state_r != S_IDLE) || pend_full_r;
  assign dout      = dout_r;
  assign done      = done_r;

  // Next-state, counter, pending slot and output pattern selection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    dout_s      = dout_r;
    done_s      = 1'b0;
    pend_full_s = pend_full_r;
    pend_code_s = pend_code_r;
    case (state_r)
      S_IDLE: begin
        if (pend_full_r) begin
          dout_s      = onehot(pend_code_r);
          pend_full_s = 1'b0;
          cnt_s       = HOLD_LD;
          state_s     = S_DRIVE;
        end else if (accept_s) begin
          dout_s  = onehot(din);
          cnt_s   = HOLD_LD;
          state_s = S_DRIVE;
        end else begin
          dout_s = {W{1'b0}};
        end
      end
      S_DRIVE: begin
        // A code arriving now waits in the slot; it is never consumed on
        // the edge that captures it.
        if (accept_s) begin
          pend_code_s = din;
          pend_full_s = 1'b1;
        end else begin
          pend_code_s = pend_code_r;
        end
        if (cnt_r != {CW{1'b0}}) begin
          cnt_s = cnt_r - CW'(1);
        end else begin
          done_s = 1'b1;
          if (GAP > 0) begin
            dout_s  = {W{1'b0}};
            cnt_s   = GAP_LD;
            state_s = S_GAP;
          end else if (pend_full_r) begin
            // No gap: the next pattern follows without a zero cycle.
            dout_s      = onehot(pend_code_r);
            pend_full_s = 1'b0;
            cnt_s       = HOLD_LD;
          end else begin
            dout_s  = {W{1'b0}};
            state_s = S_IDLE;
          end
        end
      end
      S_GAP: begin
        dout_s = {W{1'b0}};
        if (accept_s) begin
          pend_code_s = din;
          pend_full_s = 1'b1;
        end else begin
          pend_code_s = pend_code_r;
        end
        if (cnt_r != {CW{1'b0}}) begin
          cnt_s = cnt_r - CW'(1);
        end else if (pend_full_r) begin
          dout_s      = onehot(pend_code_r);
          pend_full_s = 1'b0;
          cnt_s       = HOLD_LD;
          state_s     = S_DRIVE;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s     = S_IDLE;
        cnt_s       = {CW{1'b0}};
        dout_s      = {W{1'b0}};
        pend_full_s = 1'b0;
      end
    endcase
  end

  // State, counter, pending slot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CW{1'b0}};
      dout_r      <= {W{1'b0}};
      done_r      <= 1'b0;
      pend_full_r <= 1'b0;
      pend_code_r <= {N{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      dout_r      <= dout_s;
      done_r      <= done_s;
      pend_full_r <= pend_full_s;
      pend_code_r <= pend_code_s;
    end
  end

`ifdef DECODER_LOOPBACK_EN
  logic          load_s;
  logic [N-1:0]  load_code_s;
  logic          chk_bad_s;
  logic [N-1:0]  code_r;
  logic          err_r;

  // Lowest-set-bit priority encoder used to recover the index from dout.
  function automatic logic [N-1:0] enc_low(input logic [W-1:0] v);
    logic [N-1:0] r;
    r = {N{1'b0}};
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = N'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [W-1:0] v);
    return (v != {W{1'b0}}) && ((v & (v - W'(1))) == {W{1'b0}});
  endfunction

  // Detect pattern loads and compare the live output against the loaded code.
  always_comb begin
    load_s      = (state_s == S_DRIVE) &&
                  ((state_r != S_DRIVE) || (cnt_r == {CW{1'b0}}));
    load_code_s = pend_full_r ? pend_code_r : din;
    chk_bad_s   = (dout_r != {W{1'b0}}) &&
                  (!is_onehot(dout_r) || (enc_low(dout_r) != code_r));
  end

  // Keep the last loaded code and latch any loopback failure until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r <= {N{1'b0}};
      err_r  <= 1'b0;
    end else begin
      code_r <= load_s ? load_code_s : code_r;
      err_r  <= err_r | chk_bad_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Self-checking bench for dec_onehot_seq: directed scenarios with fixed
// expectations plus a randomized run checked against a schedule-queue model.
module tb_dec_onehot_seq;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic       clk, rst_n;
  logic [2:0] din;
  logic       din_valid, din_ready, busy, done, err;
  logic [7:0] dout;
  logic [2:0] b_din;
  logic       b_din_valid, b_din_ready, b_busy, b_done, b_err;
  logic [7:0] b_dout;

  int total = 0;
  int bad   = 0;

  dec_onehot_seq #(.N(3), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .busy(busy), .done(done), .err(err)
  );

  dec_onehot_seq #(.N(3), .HOLD(2), .GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_din_valid),
    .din_ready(b_din_ready), .dout(b_dout), .busy(b_busy), .done(b_done), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: queue of scheduled output cycles ----
  typedef struct packed { logic [7:0] val; logic last; } ent_t;
  ent_t       mq[$];
  bit         m_pend_full;
  logic [2:0] m_pend_code;
  bit         m_done;

  task automatic m_reset();
    mq.delete();
    m_pend_full = 1'b0;
    m_pend_code = 3'd0;
    m_done      = 1'b0;
  endtask

  task automatic m_start(input logic [2:0] code);
    ent_t e;
    for (int i = 0; i < HOLD; i++) begin
      e.val  = 8'd1 << code;
      e.last = (i == HOLD - 1);
      mq.push_back(e);
    end
    for (int i = 0; i < GAP; i++) begin
      e.val  = 8'd0;
      e.last = 1'b0;
      mq.push_back(e);
    end
  endtask

  task automatic m_step(input bit v, input logic [2:0] d);
    bit acc, was_idle;
    acc      = v && !m_pend_full;
    was_idle = (mq.size() == 0);
    m_done   = !was_idle && mq[0].last;
    if (was_idle) begin
      if (m_pend_full) begin
        m_start(m_pend_code);
        m_pend_full = 1'b0;
      end else if (acc) begin
        m_start(d);
      end
    end else begin
      void'(mq.pop_front());
      if (mq.size() == 0 && m_pend_full) begin
        m_start(m_pend_code);
        m_pend_full = 1'b0;
      end
      if (acc) begin
        m_pend_code = d;
        m_pend_full = 1'b1;
      end
    end
  endtask

  // ---------------- utilities --------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid   = 1'b0;
    b_din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    m_reset();
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && busy; i++) tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_timeout busy=%b want 0", busy);
    end
  endtask

  // ---------------- scenarios --------------------------------------------
  task automatic test_reset();
    #3;
    total += 6;
    if (dout !== 8'h00)     begin bad++; $display("FAIL rst_dout got=%h want 00", dout); end
    if (din_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want 1", din_ready); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want 0", busy); end
    if (done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b want 0", done); end
    if (err !== 1'b0)       begin bad++; $display("FAIL rst_err got=%b want 0", err); end
    if (b_dout !== 8'h00)   begin bad++; $display("FAIL rst_b_dout got=%h want 00", b_dout); end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    din = 3'd5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      total += 3;
      if (dout !== ((c <= 4) ? 8'h20 : 8'h00)) begin
        bad++; $display("FAIL single_dout c=%0d got=%h", c, dout);
      end
      if (done !== (c == 5)) begin
        bad++; $display("FAIL single_done c=%0d got=%b want %b", c, done, (c == 5));
      end
      if (busy !== (c <= 5)) begin
        bad++; $display("FAIL single_busy c=%0d got=%b want %b", c, busy, (c <= 5));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed;
    din = 3'd0; din_valid = 1'b1;
    tick();
    din = 3'd7;
    for (int c = 1; c <= 9; c++) begin
      ed = (c <= 4) ? 8'h01 : ((c == 5) ? 8'h00 : 8'h80);
      total += 2;
      if (dout !== ed) begin
        bad++; $display("FAIL b2b_dout c=%0d got=%h want %h", c, dout, ed);
      end
      if (din_ready !== !(c >= 2 && c <= 5)) begin
        bad++; $display("FAIL b2b_ready c=%0d got=%b", c, din_ready);
      end
      if (c == 6) din_valid = 1'b0;
      tick();
    end
    drain();
  endtask

  task automatic test_gap0();
    logic [7:0] ed;
    b_din = 3'd3; b_din_valid = 1'b1;
    tick();
    for (int c = 1; c <= 6; c++) begin
      ed = (c <= 2) ? 8'h08 : ((c <= 4) ? 8'h40 : 8'h00);
      total += 2;
      if (b_dout !== ed) begin
        bad++; $display("FAIL gap0_dout c=%0d got=%h want %h", c, b_dout, ed);
      end
      if (b_done !== (c == 3 || c == 5)) begin
        bad++; $display("FAIL gap0_done c=%0d got=%b", c, b_done);
      end
      if (c == 1) b_din = 3'd6;
      if (c == 2) b_din_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_hold_third();
    logic [7:0] ed;
    logic       er;
    din = 3'd1; din_valid = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      ed = (c <= 4) ? 8'h02 : (c >= 6 && c <= 9) ? 8'h10 :
           (c >= 11 && c <= 14) ? 8'h04 : 8'h00;
      er = !((c >= 2 && c <= 5) || (c >= 7 && c <= 10));
      total += 2;
      if (dout !== ed) begin
        bad++; $display("FAIL third_dout c=%0d got=%h want %h", c, dout, ed);
      end
      if (din_ready !== er) begin
        bad++; $display("FAIL third_ready c=%0d got=%b want %b", c, din_ready, er);
      end
      if (c == 1) din = 3'd4;
      if (c == 2) din = 3'd2;
      if (c == 7) din_valid = 1'b0;
      tick();
    end
    drain();
  endtask

  task automatic test_async_reset();
    din = 3'd3; din_valid = 1'b1;
    tick();
    din = 3'd6;
    tick();
    din_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total += 4;
    if (dout !== 8'h00)     begin bad++; $display("FAIL arst_dout got=%h want 00", dout); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL arst_busy got=%b want 0", busy); end
    if (din_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want 1", din_ready); end
    if (done !== 1'b0)      begin bad++; $display("FAIL arst_done got=%b want 0", done); end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      total += 2;
      if (dout !== 8'h00) begin bad++; $display("FAIL arst_stale_dout c=%0d got=%h", c, dout); end
      if (busy !== 1'b0)  begin bad++; $display("FAIL arst_stale_busy c=%0d got=%b", c, busy); end
    end
  endtask

  task automatic test_random();
    bit         v;
    logic [2:0] d;
    logic [7:0] ed;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ed = (mq.size() != 0) ? mq[0].val : 8'h00;
      total += 5;
      if (dout !== ed) begin
        bad++; $display("FAIL rnd_dout c=%0d got=%h want %h", c, dout, ed);
      end
      if (done !== m_done) begin
        bad++; $display("FAIL rnd_done c=%0d got=%b want %b", c, done, m_done);
      end
      if (din_ready !== !m_pend_full) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%b want %b", c, din_ready, !m_pend_full);
      end
      if (busy !== ((mq.size() != 0) || m_pend_full)) begin
        bad++; $display("FAIL rnd_busy c=%0d got=%b", c, busy);
      end
      if (err !== 1'b0) begin
        bad++; $display("FAIL rnd_err c=%0d got=%b want 0", c, err);
      end
      v = ($urandom_range(0, 99) < ((c < 300) ? 35 : 80));
      d = 3'($urandom_range(0, 7));
      din = d; din_valid = v;
      m_step(v, d);
      tick();
    end
    din_valid = 1'b0;
    drain();
  endtask

`ifdef DECODER_LOOPBACK_EN
  task automatic test_loopback();
    int wait_n;
    do_reset();
    for (int code = 0; code < 8; code++) begin
      din = 3'(code); din_valid = 1'b1;
      wait_n = 0;
      while (din_ready !== 1'b1 && wait_n < 50) begin
        tick();
        wait_n++;
      end
      tick();
    end
    din_valid = 1'b0;
    drain();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL lb_sweep_err got=%b want 0", err); end
    force dut.dout_r = 8'h03;
    tick();
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL lb_force_err got=%b want 1", err); end
    release dut.dout_r;
    repeat (3) tick();
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL lb_sticky_err got=%b want 1", err); end
    do_reset();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL lb_reset_err got=%b want 0", err); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    din = 3'd0; din_valid = 1'b0;
    b_din = 3'd0; b_din_valid = 1'b0;
    m_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_gap0();
    test_hold_third();
    test_async_reset();
    test_random();
`ifdef DECODER_LOOPBACK_EN
    test_loopback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
